// File: rtl/shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings, fill modes
// and the operand-width helpers.
package shifter_pipe_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  // Every op is executed as a right shift; left ops are bit-reversed around it.
  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_SIGN = 2'b01,
    FILL_ROT  = 2'b10
  } fill_e;

  localparam int WORD_W   = 32;
  localparam int WORD_SHW = 5;

  function automatic int shw_of(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One pipeline stage: applies shift levels LO..HI-1 and registers the result with
// its control and tag. The first stage pre-reverses, the last one applies fix-ups.
module shifter_pipe_stage
  import shifter_pipe_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int SHW   = 6,
  parameter int TAGW  = 4,
  parameter int LO    = 0,
  parameter int HI    = 1,
  parameter bit FIRST = 1'b0,
  parameter bit LAST  = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            adv_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  fill_e           mode_i,
  input  logic            rev_i,
  input  logic            word_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o,
  output logic [SHW-1:0]  shamt_o,
  output fill_e           mode_o,
  output logic            rev_o,
  output logic            word_o,
  output logic [TAGW-1:0] tag_o
);

  logic            valid_q;
  logic [XLEN-1:0] data_q, data_d;
  logic [SHW-1:0]  shamt_q;
  fill_e           mode_q;
  logic            rev_q, word_q;
  logic [TAGW-1:0] tag_q;

  function automatic logic [XLEN-1:0] rev_bits(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int b = 0; b < XLEN; b++) r[b] = v[XLEN-1-b];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int b = WORD_W; b < XLEN; b++) r[b] = v[WORD_W-1];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] v, input fill_e m, input int k);
    logic [XLEN-1:0] r;
    int sh;
    sh = 1 << k;
    case (m)
      FILL_SIGN: r = $signed(v) >>> sh;
      FILL_ROT:  r = (v >> sh) | (v << (XLEN - sh));
      default:   r = v >> sh;
    endcase
    return r;
  endfunction

  // Shift levels owned by this stage, bracketed by the reversal / word fix-ups.
  always_comb begin
    data_d = (FIRST && rev_i) ? rev_bits(data_i) : data_i;
    for (int k = 0; k < SHW; k++) begin
      data_d = (k >= LO && k < HI && shamt_i[k]) ? shift_lvl(data_d, mode_i, k) : data_d;
    end
    data_d = (LAST && rev_i)  ? rev_bits(data_d)  : data_d;
    data_d = (LAST && word_i) ? sext_word(data_d) : data_d;
  end

  // Valid bit: flush empties the stage even while the pipe is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (adv_i) begin
      valid_q <= valid_i;
    end
  end

  // Payload registers hold while the pipe is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= {XLEN{1'b0}};
      shamt_q <= {SHW{1'b0}};
      mode_q  <= FILL_ZERO;
      rev_q   <= 1'b0;
      word_q  <= 1'b0;
      tag_q   <= {TAGW{1'b0}};
    end else if (adv_i) begin
      data_q  <= data_d;
      shamt_q <= shamt_i;
      mode_q  <= mode_i;
      rev_q   <= rev_i;
      word_q  <= word_i;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;
  assign rev_o   = rev_q;
  assign word_o  = word_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR, optional 32-bit word mode) with
// valid/ready handshakes, in-order tags and synchronous flush.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_data,
  input  logic [$clog2(XLEN)-1:0]  in_shamt,
  input  logic [2:0]               in_op,
  input  logic                     in_word,
  input  logic [TAGW-1:0]          in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic [TAGW-1:0]          out_tag
);

  localparam int SHW = shw_of(XLEN);
  localparam int PER = (SHW + STAGES - 1) / STAGES;
  localparam logic [SHW-1:0] WORD_MASK = SHW'(32'd31);

  logic                 adv_s;
  logic                 word_s, rev_s;
  fill_e                mode_s;
  logic [SHW-1:0]       shamt_s;
  logic [XLEN-1:0]      opnd_s;
  logic [WORD_W-1:0]    lo_s;

  logic [STAGES:0]      v_s, r_s, w_s;
  logic [XLEN-1:0]      d_s [STAGES+1];
  logic [SHW-1:0]       sh_s [STAGES+1];
  fill_e                m_s [STAGES+1];
  logic [TAGW-1:0]      t_s [STAGES+1];

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // Decode op into fill mode / reversal; word mode rebuilds the upper half so a
  // plain XLEN-wide right shift yields the 32-bit result in the low half.
  always_comb begin
    word_s  = (XLEN > WORD_W) && in_word;
    lo_s    = in_data[WORD_W-1:0];
    mode_s  = FILL_ZERO;
    rev_s   = 1'b0;
    shamt_s = in_shamt;
    case (in_op)
      OP_SLL:  rev_s = 1'b1;
      OP_SRL:  rev_s = 1'b0;
      OP_SRA:  mode_s = FILL_SIGN;
      OP_ROL:  begin mode_s = FILL_ROT; rev_s = 1'b1; end
      OP_ROR:  mode_s = FILL_ROT;
      default: shamt_s = {SHW{1'b0}};
    endcase
    shamt_s = word_s ? (shamt_s & WORD_MASK) : shamt_s;
    for (int b = 0; b < XLEN; b++) begin
      if (!word_s || b < WORD_W) begin
        opnd_s[b] = in_data[b];
      end else if (mode_s == FILL_ROT) begin
        opnd_s[b] = lo_s[b % WORD_W];
      end else if (mode_s == FILL_SIGN) begin
        opnd_s[b] = lo_s[WORD_W-1];
      end else begin
        opnd_s[b] = 1'b0;
      end
    end
  end

  assign v_s[0]  = in_valid;
  assign d_s[0]  = opnd_s;
  assign sh_s[0] = shamt_s;
  assign m_s[0]  = mode_s;
  assign r_s[0]  = rev_s;
  assign w_s[0]  = word_s;
  assign t_s[0]  = in_tag;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO_P = i * PER;
    localparam int HI_P = (i == STAGES - 1) ? SHW : (((i + 1) * PER < SHW) ? (i + 1) * PER : SHW);
    shifter_pipe_stage #(
      .XLEN  (XLEN),
      .SHW   (SHW),
      .TAGW  (TAGW),
      .LO    (LO_P),
      .HI    (HI_P),
      .FIRST (i == 0),
      .LAST  (i == STAGES - 1)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .adv_i   (adv_s),
      .flush_i (flush),
      .valid_i (v_s[i]),
      .data_i  (d_s[i]),
      .shamt_i (sh_s[i]),
      .mode_i  (m_s[i]),
      .rev_i   (r_s[i]),
      .word_i  (w_s[i]),
      .tag_i   (t_s[i]),
      .valid_o (v_s[i+1]),
      .data_o  (d_s[i+1]),
      .shamt_o (sh_s[i+1]),
      .mode_o  (m_s[i+1]),
      .rev_o   (r_s[i+1]),
      .word_o  (w_s[i+1]),
      .tag_o   (t_s[i+1])
    );
  end

  assign out_valid = v_s[STAGES];
  assign out_data  = d_s[STAGES];
  assign out_tag   = t_s[STAGES];

  logic unused_s;
  assign unused_s = ^{sh_s[STAGES], r_s[STAGES], w_s[STAGES], m_s[STAGES], in_word};

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 or 64.
REQ-002 Parameter STAGES, default 2, register stages; legal range 1..log2(XLEN).
REQ-003 Parameter TAGW, default 4, width of the pass-through tag.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  input request present.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_data  in  XLEN  operand.
REQ-009 in_shamt  in  log2(XLEN)  shift amount.
REQ-010 in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
REQ-011 in_word  in  1  32-bit word-mode operation; ignored when XLEN=32.
REQ-012 in_tag  in  TAGW  opaque tag carried with the operation.
REQ-013 flush  in  1  synchronous discard of all in-flight operations.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_data  out  XLEN  result.
REQ-017 out_tag  out  TAGW  tag of the result.

Function
REQ-018 Input transfer SHALL occur when in_valid && in_ready && !flush; output transfer when out_valid && out_ready.
REQ-019 Pipeline SHALL advance as one unit when adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-020 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when adv is held high; one result per cycle throughput.
REQ-021 When adv=0, all stage registers, out_data, and out_tag SHALL hold; out_valid SHALL stay asserted until transferred.
REQ-022 Empty stages (valid=0) SHALL be overwritten on advance; bubbles are not compacted.
REQ-023 log2(XLEN) shift levels (2^0..2^(L-1)) SHALL be assigned lowest-first, ceil(L/STAGES) levels per stage; the last stage takes the remainder and the final fix-ups.
REQ-024 SLL/SRL SHALL zero-fill; SRA SHALL fill with operand MSB; ROL/ROR SHALL rotate modulo the operand width.
REQ-025 Word mode (XLEN=64, in_word=1): operand is in_data[31:0]; amount is in_shamt[4:0] with bit 5 ignored; SRA fills from bit 31; rotates are 32-bit; the 32-bit result SHALL be sign-extended from bit 31 to 64 bits.
REQ-026 Reserved ops SHALL return in_data unchanged (word mode: sign-extended low 32 bits).
REQ-027 shamt=0 SHALL return the operand (word mode: sign-extended).
REQ-028 out_tag SHALL equal in_tag of the same operation; results SHALL leave in acceptance order.
REQ-029 flush SHALL clear every stage valid and out_valid on the next edge; data/tag registers need not clear.
REQ-030 A transfer with out_valid && out_ready in the flush cycle SHALL complete normally; in_valid in the flush cycle SHALL be dropped.

Reset
REQ-031 While rst_n=0, all stage valids and out_valid SHALL be 0, out_data and out_tag 0, and in_ready 1.
REQ-032 Assertion mid-operation SHALL discard all in-flight operations immediately, with no partial result emitted after release.
REQ-033 The first input transfer SHALL be possible in the first clk edge after rst_n rises.

Structure
REQ-034 A shared package SHALL hold the in_op encodings (SLL, SRL, SRA, ROL, ROR) and a log2-width helper constant.
REQ-035 One sub-module, shifter_pipe_stage, SHALL implement a configurable run of shift levels plus valid/data/tag registers and be instantiated STAGES times.

Verification
REQ-036 XLEN=64, STAGES=2: data 0x8000000000000000, shamt 63, SRA -> out_data 0xFFFFFFFFFFFFFFFF, out_valid 2 cycles after accept.
REQ-037 data 0x0123456789ABCDEF, shamt 8: ROR -> 0xEF0123456789ABCD; ROL -> 0x23456789ABCDEF01.
REQ-038 Word mode, data 0xFFFFFFFF80000000, shamt 4 (then shamt 36): SRL -> 0x0000000008000000; SRA -> 0xFFFFFFFFF8000000; both shamts give the same results.
REQ-039 Back-to-back inputs with tags 0..7 and out_ready low for 5 cycles: in_ready falls once 2 items are held; no loss or duplication; tags emerge in order 0..7.
REQ-040 Two items in flight, then flush: out_valid=0 next cycle, flushed tags never appear, and the next input emerges 2 cycles after accept.
REQ-041 rst_n pulsed low with 2 items in flight: out_valid=0 and in_ready=1 during reset; no stale output after release.
